// File: rtl/timebase_pkg.sv
// Shared types for the time-base counter: run-mode encoding.
package timebase_pkg;

  // Counter run modes, selected on the mode input.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_PERIODIC = 2'd3
  } mode_e;

endpackage

// File: rtl/timebase_cnt_if.sv
// Control/status bundle of the time-base counter. The master side drives
// run control, load and compare values; the slave side (the counter)
// returns count, tick, match and the flags.
interface timebase_cnt_if
  import timebase_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  mode_e            mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             match;
  logic             ovf;
  logic             done;

  modport master (
    output en, clr, load, load_val, cmp_val, mode, ovf_clr,
    input  cnt, tick, match, ovf, done
  );

  modport slave (
    input  en, clr, load, load_val, cmp_val, mode, ovf_clr,
    output cnt, tick, match, ovf, done
  );

endinterface

// File: rtl/timebase_cnt_tick_prescaler.sv
// Prescaler: counts running clk cycles and flags the last cycle of each
// DIV-cycle period. The flag is combinational; the caller registers it.
module tick_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic sync_clr,
  output logic tick_evt
);

  // DIV=1 still needs a one-bit register; it simply stays at zero.
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);

  logic [PW-1:0] pre_r;

  assign tick_evt = run & ~sync_clr & (pre_r == PRE_LAST);

  // Period position: cleared by clr/load, frozen when not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r <= PRE_ZERO;
    end else if (sync_clr) begin
      pre_r <= PRE_ZERO;
    end else if (run) begin
      if (pre_r == PRE_LAST) begin
        pre_r <= PRE_ZERO;
      end else begin
        pre_r <= pre_r + PRE_ONE;
      end
    end else begin
      pre_r <= pre_r;
    end
  end

endmodule

// File: rtl/timebase_cnt.sv
// Parametrised time-base counter: prescaled tick, WIDTH-bit count with
// wrap / saturate / one-shot / periodic modes, match pulse, sticky
// overflow and one-shot done flag.
module timebase_cnt
  import timebase_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV   = 100000
) (
  input  logic          clk,
  input  logic          reset,
  timebase_cnt_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);

  logic [WIDTH-1:0] cnt_r;
  logic             tick_r;
  logic             match_r;
  logic             ovf_r;
  logic             done_r;

  logic [WIDTH-1:0] cnt_nxt_s;
  logic             match_nxt_s;
  logic             ovf_set_s;
  logic             done_set_s;
  logic             tick_evt_s;
  logic             run_s;
  logic             pre_clr_s;

  // A finished one-shot freezes the prescaler until clr or load.
  assign run_s     = bus.en & ~done_r;
  assign pre_clr_s = bus.clr | bus.load;

  tick_prescaler #(
    .DIV (DIV)
  ) u_tick_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (run_s),
    .sync_clr (pre_clr_s),
    .tick_evt (tick_evt_s)
  );

  // Count value, overflow and done requests for a tick in the current mode.
  always_comb begin
    cnt_nxt_s  = cnt_r + CNT_ONE;
    ovf_set_s  = 1'b0;
    done_set_s = 1'b0;
    case (bus.mode)
      MODE_WRAP: begin
        ovf_set_s = (cnt_r == CNT_MAX);
      end
      MODE_SAT: begin
        if (cnt_r == CNT_MAX) begin
          cnt_nxt_s = CNT_MAX;
          ovf_set_s = 1'b1;
        end else begin
          ovf_set_s = 1'b0;
        end
      end
      MODE_ONESHOT: begin
        ovf_set_s  = (cnt_r == CNT_MAX);
        done_set_s = (cnt_nxt_s == bus.cmp_val);
      end
      MODE_PERIODIC: begin
        if (cnt_r == bus.cmp_val) begin
          cnt_nxt_s = CNT_ZERO;
        end else begin
          ovf_set_s = (cnt_r == CNT_MAX);
        end
      end
      default: begin
        ovf_set_s = (cnt_r == CNT_MAX);
      end
    endcase
    match_nxt_s = (cnt_nxt_s == bus.cmp_val);
  end

  // Count and flag registers; clr beats load beats a tick advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      tick_r  <= 1'b0;
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.clr) begin
      cnt_r   <= CNT_ZERO;
      tick_r  <= 1'b0;
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.load) begin
      cnt_r   <= bus.load_val;
      tick_r  <= 1'b0;
      match_r <= 1'b0;
      ovf_r   <= ovf_r & ~bus.ovf_clr;
      done_r  <= 1'b0;
    end else if (tick_evt_s) begin
      cnt_r   <= cnt_nxt_s;
      tick_r  <= 1'b1;
      match_r <= match_nxt_s;
      ovf_r   <= ovf_set_s | (ovf_r & ~bus.ovf_clr);
      done_r  <= done_r | done_set_s;
    end else begin
      cnt_r   <= cnt_r;
      tick_r  <= 1'b0;
      match_r <= 1'b0;
      ovf_r   <= ovf_r & ~bus.ovf_clr;
      done_r  <= done_r;
    end
  end

  assign bus.cnt   = cnt_r;
  assign bus.tick  = tick_r;
  assign bus.match = match_r;
  assign bus.ovf   = ovf_r;
  assign bus.done  = done_r;

endmodule
